ssd_scan_ctrl: RTL and testbench
================================

# ssd_scan_ctrl

Time-multiplexed scan controller for a bank of active-low seven-segment digits that share one seven-segment decoder instance. It holds a frame of hex nibbles and steps the shared decoder through them, one digit slot at a time. It registers the decoder's active-low segment output together with a one-hot active-low digit enable. Dead-time between slots prevents ghosting. New display data enters through a valid/ready handshake and becomes visible only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; legal range 2..8.
- SLOT_CYCLES, 50000: clock cycles per digit slot; must be greater than GUARD_CYCLES + 1.
- GUARD_CYCLES, 500: blanked cycles at the start of each slot; legal range is 1 or more.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  load_data and blank_mask are presented.
- load_ready  out  1  shadow register is empty and can accept a load.
- load_data  in  4*NUM_DIGITS  nibble i is at bits [4i+3:4i]; digit 0 is the rightmost digit.
- blank_mask  in  NUM_DIGITS  bit i set means digit i stays dark.
- dec_in  out  4  nibble presented to the shared decoder (combinational from the active register and the slot index).
- dec_out  in  7  active-low segments returned by the shared decoder (combinational).
- seg_n  out  7  registered active-low segments driven to the display.
- dig_n  out  NUM_DIGITS  registered active-low one-hot digit enable.

## Operation
- Counters:
  - cnt runs 0..SLOT_CYCLES-1.
  - idx runs 0..NUM_DIGITS-1 and increments when cnt wraps.
  - idx wraps to 0 after NUM_DIGITS-1; that wrap is the frame end.
- FSM is evaluated each cycle from cnt:
  - GUARD while cnt < GUARD_CYCLES.
  - DRIVE otherwise.
  - The GUARD to DRIVE transition occurs when cnt reaches GUARD_CYCLES.
  - The DRIVE to GUARD transition occurs on the cnt wrap.
- dec_in = active[idx] in all states.
- Output register updates:
  - In GUARD: seg_n <= 7'h7F, dig_n <= all ones.
  - In DRIVE with active_mask[idx] = 0: seg_n <= dec_out, and dig_n <= all ones except bit idx, which is 0.
  - In DRIVE with active_mask[idx] = 1: behaves like GUARD.
- Two-deep buffering: a shadow register (data, mask, full flag) and an active register (data, mask).
  - load_ready = !shadow_full.
  - When load_valid && load_ready in a cycle, the shadow captures the load and shadow_full is set.
  - At the frame end (idx = NUM_DIGITS-1 and cnt = SLOT_CYCLES-1), if shadow_full: active <= shadow and shadow_full is cleared.
- A load accepted in the frame-end cycle itself goes into the shadow only. It commits at the next frame end; there is no bypass to the active register.
- load_valid while load_ready = 0 is ignored. The source must hold its data until accepted.
- Reset (asynchronous, takes effect immediately):
  - cnt = 0, idx = 0, state = GUARD.
  - active data = 0, active mask = all zeros.
  - shadow_full = 0, so load_ready = 1.
  - seg_n = 7'h7F, dig_n = all ones.
- Reset asserted mid-frame or mid-handshake discards both the shadow and active contents. Scanning restarts at digit 0 in GUARD after release.

## Timing
- The decoder path is combinational: idx drives dec_in, which produces dec_out, which is registered into seg_n. seg_n and dig_n change on the same edge.
- Outputs lag the FSM state by 1 cycle.
  - dig_n goes low at cycle GUARD_CYCLES+1 of a slot (counting from the cnt=0 edge).
  - dig_n goes high 1 cycle after the wrap.
- Load-to-display latency ranges from 1 to NUM_DIGITS×SLOT_CYCLES cycles until commit, plus GUARD_CYCLES+1 cycles until digit 0 is lit.
- load_ready falls the cycle after acceptance and rises the cycle after the frame-end commit.

## Configuration
- SSD_SCAN_LEADING_ZERO_BLANK_EN is a preprocessor macro.
- When defined, a digit is also forced dark if it is not digit 0 and every nibble from its own position up to the highest digit is 0. Example: 16'h0042 displays "42" on digits 0..1, with digits 2..3 dark.
- Digit 0 is never suppressed by this feature.
- When undefined, only blank_mask darkens digits, and zeros are shown.

## Test plan
All scenarios use NUM_DIGITS=4, SLOT_CYCLES=8, GUARD_CYCLES=2.
- Reset release, then 80 cycles with no load:
  - seg_n = 7'h7F.
  - dig_n = 4'b1111 in every GUARD cycle.
  - dig_n cycles through 4'b1110, 4'b1101, 4'b1011, 4'b0111 for 6 cycles each, with seg_n = 7'h40 ("0" pattern from the decoder).
- Load 16'h1234 with mask 0:
  - load_ready drops.
  - After the frame end: digit 0 shows the "4" pattern (7'h19) and digit 3 shows "1" (7'h79).
  - load_ready rises 1 cycle after the frame end.
- Back-to-back loads: 16'hAAAA accepted, then 16'h5555 held valid.
  - 16'h5555 stalls until the commit of AAAA and is accepted in the next cycle.
  - 16'h5555 becomes visible only after a further frame end.
- blank_mask = 4'b0101 with data 16'h8888:
  - Digits 0 and 2 never have dig_n low.
  - Digits 1 and 3 show 7'h00.
- rst_n pulsed low in the middle of digit 2's DRIVE while the shadow is full:
  - seg_n = 7'h7F and dig_n = 4'b1111 immediately.
  - load_ready = 1.
  - After release, the display scans zeros starting at digit 0.
- With SSD_SCAN_LEADING_ZERO_BLANK_EN defined, load 16'h0007:
  - Only digit 0 lights, with 7'h78.
  - Loading 16'h0000 lights only digit 0, with 7'h40.

Source files
------------

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: time-multiplexed scan controller for a bank of active-low
// seven-segment digits that share one external combinational decoder.
//
// The controller walks one digit slot at a time. Each slot begins with a
// blanked guard interval so the previous digit's segments never ghost onto
// the next digit.
//
// New frames enter a shadow register through a valid/ready handshake. They
// are promoted to the active register only at a frame end, so a single
// frame never mixes old and new digits.
//
// Build option: define SSD_SCAN_LEADING_ZERO_BLANK_EN to darken leading-zero
// digits. Digit 0 is never suppressed.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_GUARD | cnt < GUARD_CYCLES: blank segments, all digits disabled
// ST_DRIVE | remainder of slot: drive decoder output on digit idx
module ssd_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [3:0]              dec_in,
  input  logic [6:0]              dec_out,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   dig_n
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {ST_GUARD, ST_DRIVE} state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic                    slot_end;
  logic                    frame_end;

  logic [4*NUM_DIGITS-1:0] shadow_data;
  logic [NUM_DIGITS-1:0]   shadow_mask;
  logic                    shadow_full;
  logic [4*NUM_DIGITS-1:0] active_data;
  logic [NUM_DIGITS-1:0]   active_mask;

  logic [NUM_DIGITS-1:0]   lz_dark;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    cur_dark;
  logic [6:0]              seg_next;
  logic [NUM_DIGITS-1:0]   dig_next;

  assign slot_end   = (cnt == CNT_LAST);
  assign frame_end  = slot_end && (idx == IDX_LAST);
  assign load_ready = !shadow_full;

  // Slot cycle counter and digit index; the idx wrap marks the frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow capture on handshake; promote shadow to active at frame end.
  // A full shadow blocks acceptance, so both branches never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_data <= '0;
      shadow_mask <= '0;
      shadow_full <= 1'b0;
      active_data <= '0;
      active_mask <= '0;
    end else if (load_valid && !shadow_full) begin
      shadow_data <= load_data;
      shadow_mask <= blank_mask;
      shadow_full <= 1'b1;
    end else if (frame_end && shadow_full) begin
      active_data <= shadow_data;
      active_mask <= shadow_mask;
      shadow_full <= 1'b0;
    end
  end

`ifdef SSD_SCAN_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every higher digit are zero.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_dark    = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (active_data[4*i +: 4] == 4'h0);
      lz_dark[i] = zero_above;
    end
  end
`else
  assign lz_dark = '0;
`endif

  // Select the current digit's nibble, darkening and one-hot enable.
  always_comb begin
    dec_in   = 4'h0;
    cur_dark = 1'b0;
    dig_sel  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        dec_in     = active_data[4*i +: 4];
        cur_dark   = active_mask[i] | lz_dark[i];
        dig_sel[i] = 1'b0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_GUARD;
    else        state <= state_next;
  end

  // Next state tracks cnt; output targets for the registered display drive.
  always_comb begin
    state_next = state;
    seg_next   = 7'h7F;
    dig_next   = '1;
    case (state)
      ST_GUARD: begin
        if (cnt == GUARD_LAST) state_next = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (slot_end) state_next = ST_GUARD;
        if (!cur_dark) begin
          seg_next = dec_out;
          dig_next = dig_sel;
        end
      end
      default: state_next = ST_GUARD;
    endcase
  end

  // Segment and digit drivers change together on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n <= 7'h7F;
      dig_n <= '1;
    end else begin
      seg_n <= seg_next;
      dig_n <= dig_next;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with NUM_DIGITS=4, SLOT_CYCLES=8 and
// GUARD_CYCLES=2. One frame is 32 cycles.
//
// After reset release, ecount counts rising edges. The registered outputs
// seen after edge e reflect cycle k = e-1. Cycle k is in digit (k%32)/8,
// and that digit is lit while k%8 >= 2.
module tb_ssd_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  blank_mask;
  logic [3:0]  dec_in;
  logic [6:0]  dec_out;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;

  int checks = 0;
  int errors = 0;
  int ecount = 0;

  ssd_scan_ctrl #(.NUM_DIGITS(4), .SLOT_CYCLES(8), .GUARD_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .blank_mask(blank_mask), .dec_in(dec_in),
    .dec_out(dec_out), .seg_n(seg_n), .dig_n(dig_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared external decoder, active-low gfedcba.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  assign dec_out = hex7(dec_in);

  function automatic logic [3:0] lz_mask(input logic [15:0] d);
    logic [3:0] r;
    r = 4'b0000;
`ifdef SSD_SCAN_LEADING_ZERO_BLANK_EN
    begin
      logic z;
      z = 1'b1;
      for (int i = 3; i >= 1; i--) begin
        z = z & (d[4*i +: 4] == 4'h0);
        r[i] = z;
      end
    end
`endif
    return r;
  endfunction

  function automatic logic [3:0] exp_dig(input int k, input logic [15:0] d, input logic [3:0] m);
    int pos, dg, c;
    logic [3:0] dark;
    pos  = k % 32;
    dg   = pos / 8;
    c    = pos % 8;
    dark = m | lz_mask(d);
    if (c >= 2 && dark[dg] == 1'b0) return ~(4'b0001 << dg);
    return 4'hF;
  endfunction

  function automatic logic [6:0] exp_seg(input int k, input logic [15:0] d, input logic [3:0] m);
    int pos, dg, c;
    logic [3:0] dark;
    pos  = k % 32;
    dg   = pos / 8;
    c    = pos % 8;
    dark = m | lz_mask(d);
    if (c >= 2 && dark[dg] == 1'b0) return hex7(d[4*dg +: 4]);
    return 7'h7F;
  endfunction

  task automatic step();
    @(posedge clk);
    ecount++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] d;
    logic [3:0]  m;
    int k;
    checks++; if (seg_n !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%h exp=7f", seg_n); end
    checks++; if (dig_n !== 4'hF) begin errors++; $display("FAIL reset_dig got=%b exp=1111", dig_n); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", load_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    ecount = 0;
    d = 16'h0000;
    m = 4'b0000;
    while (ecount < 80) begin
      step();
      k = ecount - 1;
      checks++; if (dig_n !== exp_dig(k, d, m)) begin errors++; $display("FAIL idle_dig e=%0d got=%b exp=%b", ecount, dig_n, exp_dig(k, d, m)); end
      checks++; if (seg_n !== exp_seg(k, d, m)) begin errors++; $display("FAIL idle_seg e=%0d got=%h exp=%h", ecount, seg_n, exp_seg(k, d, m)); end
      checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL idle_ready e=%0d got=%b exp=1", ecount, load_ready); end
    end
  endtask

  // Entered at ecount=80. Accept at edge 81, commit at edge 96.
  task automatic test_load();
    logic [15:0] d;
    logic        r;
    int k;
    load_valid = 1'b1;
    load_data  = 16'h1234;
    blank_mask = 4'b0000;
    while (ecount < 128) begin
      step();
      if (ecount == 81) load_valid = 1'b0;
      k = ecount - 1;
      d = (k >= 96) ? 16'h1234 : 16'h0000;
      r = (ecount >= 96);
      checks++; if (dig_n !== exp_dig(k, d, 4'b0)) begin errors++; $display("FAIL load_dig e=%0d got=%b exp=%b", ecount, dig_n, exp_dig(k, d, 4'b0)); end
      checks++; if (seg_n !== exp_seg(k, d, 4'b0)) begin errors++; $display("FAIL load_seg e=%0d got=%h exp=%h", ecount, seg_n, exp_seg(k, d, 4'b0)); end
      checks++; if (load_ready !== r) begin errors++; $display("FAIL load_ready e=%0d got=%b exp=%b", ecount, load_ready, r); end
    end
  endtask

  // Entered at ecount=128. AAAA is accepted at edge 129 and commits at edge 160.
  // 5555 is held valid, is accepted at edge 161 and commits at edge 192.
  task automatic test_back_to_back();
    logic [15:0] d;
    logic        r;
    int k;
    load_valid = 1'b1;
    load_data  = 16'hAAAA;
    blank_mask = 4'b0000;
    while (ecount < 223) begin
      step();
      if (ecount == 129) load_data = 16'h5555;
      k = ecount - 1;
      d = (k < 160) ? 16'h1234 : (k < 192) ? 16'hAAAA : 16'h5555;
      r = (ecount == 160) || (ecount >= 192);
      checks++; if (dig_n !== exp_dig(k, d, 4'b0)) begin errors++; $display("FAIL b2b_dig e=%0d got=%b exp=%b", ecount, dig_n, exp_dig(k, d, 4'b0)); end
      checks++; if (seg_n !== exp_seg(k, d, 4'b0)) begin errors++; $display("FAIL b2b_seg e=%0d got=%h exp=%h", ecount, seg_n, exp_seg(k, d, 4'b0)); end
      checks++; if (load_ready !== r) begin errors++; $display("FAIL b2b_ready e=%0d got=%b exp=%b", ecount, load_ready, r); end
      if (ecount == 161) load_valid = 1'b0;
    end
  endtask

  // Entered at ecount=223. The load is accepted in frame-end cycle 223, so it
  // may only commit at the following frame end (edge 256).
  task automatic test_blank_mask();
    logic [15:0] d;
    logic [3:0]  m;
    logic        r;
    int k;
    load_valid = 1'b1;
    load_data  = 16'h8888;
    blank_mask = 4'b0101;
    while (ecount < 288) begin
      step();
      if (ecount == 224) load_valid = 1'b0;
      k = ecount - 1;
      d = (k >= 256) ? 16'h8888 : 16'h5555;
      m = (k >= 256) ? 4'b0101 : 4'b0000;
      r = (ecount >= 256);
      checks++; if (dig_n !== exp_dig(k, d, m)) begin errors++; $display("FAIL blank_dig e=%0d got=%b exp=%b", ecount, dig_n, exp_dig(k, d, m)); end
      checks++; if (seg_n !== exp_seg(k, d, m)) begin errors++; $display("FAIL blank_seg e=%0d got=%h exp=%h", ecount, seg_n, exp_seg(k, d, m)); end
      checks++; if (load_ready !== r) begin errors++; $display("FAIL blank_ready e=%0d got=%b exp=%b", ecount, load_ready, r); end
    end
  endtask

  // Entered at ecount=288. 9999 is accepted at edge 289 and commits at edge 320.
  // 3333 is then accepted at edge 321 and fills the shadow. Reset is applied
  // at e=341, which is the middle of digit 2's drive window.
  task automatic test_mid_reset();
    logic [15:0] d;
    logic [3:0]  m;
    logic        r;
    int k;
    load_valid = 1'b1;
    load_data  = 16'h9999;
    blank_mask = 4'b0000;
    while (ecount < 341) begin
      step();
      if (ecount == 289) load_valid = 1'b0;
      if (ecount == 321) load_valid = 1'b0;
      k = ecount - 1;
      d = (k >= 320) ? 16'h9999 : 16'h8888;
      m = (k >= 320) ? 4'b0000 : 4'b0101;
      r = (ecount == 320);
      checks++; if (dig_n !== exp_dig(k, d, m)) begin errors++; $display("FAIL prerst_dig e=%0d got=%b exp=%b", ecount, dig_n, exp_dig(k, d, m)); end
      checks++; if (seg_n !== exp_seg(k, d, m)) begin errors++; $display("FAIL prerst_seg e=%0d got=%h exp=%h", ecount, seg_n, exp_seg(k, d, m)); end
      checks++; if (load_ready !== r) begin errors++; $display("FAIL prerst_ready e=%0d got=%b exp=%b", ecount, load_ready, r); end
      if (ecount == 320) begin
        load_valid = 1'b1;
        load_data  = 16'h3333;
      end
    end
    rst_n = 1'b0;
    #1;
    checks++; if (seg_n !== 7'h7F) begin errors++; $display("FAIL midrst_seg got=%h exp=7f", seg_n); end
    checks++; if (dig_n !== 4'hF) begin errors++; $display("FAIL midrst_dig got=%b exp=1111", dig_n); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", load_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    ecount = 0;
    d = 16'h0000;
    m = 4'b0000;
    while (ecount < 64) begin
      step();
      k = ecount - 1;
      checks++; if (dig_n !== exp_dig(k, d, m)) begin errors++; $display("FAIL postrst_dig e=%0d got=%b exp=%b", ecount, dig_n, exp_dig(k, d, m)); end
      checks++; if (seg_n !== exp_seg(k, d, m)) begin errors++; $display("FAIL postrst_seg e=%0d got=%h exp=%h", ecount, seg_n, exp_seg(k, d, m)); end
      checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL postrst_ready e=%0d got=%b exp=1", ecount, load_ready); end
    end
  endtask

`ifdef SSD_SCAN_LEADING_ZERO_BLANK_EN
  // Entered at ecount=64. 0007 is accepted at 65 and commits at 96.
  // 0000 is accepted at 129 and commits at 160. Only digit 0 may ever light.
  task automatic test_leading_zero();
    logic [15:0] d;
    logic [3:0]  ed;
    logic [6:0]  es;
    int k, pos;
    load_valid = 1'b1;
    load_data  = 16'h0007;
    blank_mask = 4'b0000;
    while (ecount < 192) begin
      step();
      if (ecount == 65 || ecount == 129) load_valid = 1'b0;
      k   = ecount - 1;
      pos = k % 32;
      d   = (k >= 96 && k < 160) ? 16'h0007 : 16'h0000;
      ed  = (pos >= 2 && pos < 8) ? 4'b1110 : 4'b1111;
      es  = (pos >= 2 && pos < 8) ? ((d == 16'h0007) ? 7'h78 : 7'h40) : 7'h7F;
      checks++; if (dig_n !== ed) begin errors++; $display("FAIL lz_dig e=%0d got=%b exp=%b", ecount, dig_n, ed); end
      checks++; if (seg_n !== es) begin errors++; $display("FAIL lz_seg e=%0d got=%h exp=%h", ecount, seg_n, es); end
      if (ecount == 128) begin
        load_valid = 1'b1;
        load_data  = 16'h0000;
      end
    end
  endtask
`endif

  initial begin
    rst_n      = 1'b1;
    load_valid = 1'b0;
    load_data  = 16'h0000;
    blank_mask = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    test_reset();
    test_load();
    test_back_to_back();
    test_blank_mask();
    test_mid_reset();
`ifdef SSD_SCAN_LEADING_ZERO_BLANK_EN
    test_leading_zero();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
